aes_kctl: RTL and testbench

AES_KCTL -- requirements
Module: aes_kctl

---
 rtl/aes_kctl.sv | 153 +++++++++++++++
 tb/tb_aes_kctl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_kctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : aes_kctl                                                       |
// | Purpose : AES key-expansion / round-key sequencing controller.           |
// |           Optional expansion timeout enabled by AES_KCTL_TIMEOUT_EN.     |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module aes_kctl #(
  parameter int unsigned NR      = 10,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_load,
  output logic       kexp_enable,
  input  logic       kexp_ready,
  output logic       key_valid,
  output logic       key_busy,
  input  logic       round_start,
  input  logic       round_dir,
  output logic       round_valid,
  input  logic       round_ack,
  output logic [3:0] round_idx,
  output logic       round_last,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_EXPAND = 3'd1,
    S_KEYED  = 3'd2,
    S_STREAM = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  localparam logic [3:0] c_NR = 4'(NR);

  state_t     r_state, w_state_n;
  logic [3:0] r_idx, w_idx_n;
  logic       r_dir, w_dir_n;
  logic       w_last, w_last_n, w_expired;

  logic       r_kexp_enable, r_key_valid, r_key_busy;
  logic       r_round_valid, r_round_last;
  logic [3:0] r_round_idx;

`ifdef AES_KCTL_TIMEOUT_EN
  localparam int unsigned   c_TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT - 1);

  logic [c_TW-1:0] r_tcnt, w_tcnt_n;
  logic            r_err;

  // Counter is zero on EXPAND entry and on every key_load restart.
  always_comb begin
    w_tcnt_n = '0;
    if (r_state == S_EXPAND && !key_load) w_tcnt_n = r_tcnt + c_TW'(1);
  end

  assign w_expired = (r_tcnt == c_TMAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tcnt <= '0;
      r_err  <= 1'b0;
    end else begin
      r_tcnt <= w_tcnt_n;
      r_err  <= (w_state_n == S_ERROR);
    end
  end

  assign err = r_err;
`else
  assign w_expired = 1'b0;
  assign err       = 1'b0;
`endif

  always_comb begin
    w_state_n = r_state;
    w_idx_n   = r_idx;
    w_dir_n   = r_dir;
    w_last    = r_dir ? (r_idx == 4'd0) : (r_idx == c_NR);
    case (r_state)
      S_IDLE: begin
        if (key_load) w_state_n = S_EXPAND;
      end
      S_EXPAND: begin
        // A fresh key_load restarts expansion even if ready arrives with it.
        if (key_load)        w_state_n = S_EXPAND;
        else if (kexp_ready) w_state_n = S_KEYED;
        else if (w_expired)  w_state_n = S_ERROR;
      end
      S_KEYED: begin
        if (key_load) begin
          w_state_n = S_EXPAND;
        end else if (round_start) begin
          w_state_n = S_STREAM;
          w_dir_n   = round_dir;
          w_idx_n   = round_dir ? c_NR : 4'd0;
        end
      end
      S_STREAM: begin
        if (key_load) begin
          w_state_n = S_EXPAND;
        end else if (round_ack) begin
          if (w_last)     w_state_n = S_KEYED;
          else if (r_dir) w_idx_n   = r_idx - 4'd1;
          else            w_idx_n   = r_idx + 4'd1;
        end
      end
      S_ERROR: begin
        if (key_load) w_state_n = S_EXPAND;
      end
      default: w_state_n = S_IDLE;
    endcase
    w_last_n = w_dir_n ? (w_idx_n == 4'd0) : (w_idx_n == c_NR);
  end

  // Outputs are registered from the next-state decode so they line up with r_state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= 4'd0;
      r_dir         <= 1'b0;
      r_kexp_enable <= 1'b0;
      r_key_valid   <= 1'b0;
      r_key_busy    <= 1'b0;
      r_round_valid <= 1'b0;
      r_round_last  <= 1'b0;
      r_round_idx   <= 4'd0;
    end else begin
      r_state       <= w_state_n;
      r_idx         <= w_idx_n;
      r_dir         <= w_dir_n;
      r_kexp_enable <= (w_state_n == S_EXPAND) || (w_state_n == S_KEYED) ||
                       (w_state_n == S_STREAM);
      r_key_busy    <= (w_state_n == S_EXPAND);
      r_key_valid   <= (w_state_n == S_KEYED) || (w_state_n == S_STREAM);
      r_round_valid <= (w_state_n == S_STREAM);
      r_round_last  <= (w_state_n == S_STREAM) && w_last_n;
      r_round_idx   <= (w_state_n == S_STREAM) ? w_idx_n : 4'd0;
    end
  end

  assign kexp_enable = r_kexp_enable;
  assign key_valid   = r_key_valid;
  assign key_busy    = r_key_busy;
  assign round_valid = r_round_valid;
  assign round_last  = r_round_last;
  assign round_idx   = r_round_idx;

endmodule
`default_nettype wire

// File: tb/tb_aes_kctl.sv
`default_nettype none
// Bench for aes_kctl: NR=10 and NR=14 instances on shared stimulus, checked
// against a sequence-list reference model.
module tb_aes_kctl;
  localparam int TO = 64;
`ifdef AES_KCTL_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam int M_IDLE = 0, M_EXPAND = 1, M_KEYED = 2, M_STREAM = 3, M_ERROR = 4;

  logic clk = 1'b0;
  logic rst, key_load, kexp_ready, round_start, round_dir, round_ack;

  logic       a_en, a_kv, a_kb, a_rv, a_rl, a_err;
  logic [3:0] a_idx;
  logic       b_en, b_kv, b_kb, b_rv, b_rl, b_err;
  logic [3:0] b_idx;

  aes_kctl #(.NR(10), .TIMEOUT(TO)) u_dut10 (
    .clk(clk), .rst(rst), .key_load(key_load), .kexp_enable(a_en),
    .kexp_ready(kexp_ready), .key_valid(a_kv), .key_busy(a_kb),
    .round_start(round_start), .round_dir(round_dir), .round_valid(a_rv),
    .round_ack(round_ack), .round_idx(a_idx), .round_last(a_rl), .err(a_err)
  );

  aes_kctl #(.NR(14), .TIMEOUT(TO)) u_dut14 (
    .clk(clk), .rst(rst), .key_load(key_load), .kexp_enable(b_en),
    .kexp_ready(kexp_ready), .key_valid(b_kv), .key_busy(b_kb),
    .round_start(round_start), .round_dir(round_dir), .round_valid(b_rv),
    .round_ack(round_ack), .round_idx(b_idx), .round_last(b_rl), .err(b_err)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int cyc_n  = 0;

  // Reference model: each instance holds the expected list of round indices.
  int m_st   [2];
  int m_tc   [2];
  int m_nr   [2];
  int m_seq  [2][16];
  int m_len  [2];
  int m_pos  [2];

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b required %b", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] obs_vec(input int k);
    if (k == 0) return {a_en, a_kb, a_kv, a_rv, a_rl, a_err, a_idx};
    else        return {b_en, b_kb, b_kv, b_rv, b_rl, b_err, b_idx};
  endfunction

  function automatic logic [9:0] exp_vec(input int k);
    logic [3:0] idx;
    logic       last;
    logic       strm;
    idx  = 4'd0;
    last = 1'b0;
    strm = (m_st[k] == M_STREAM);
    if (strm) begin
      idx  = 4'(m_seq[k][m_pos[k]]);
      last = (m_pos[k] == m_len[k] - 1);
    end
    return {(m_st[k] == M_EXPAND) || (m_st[k] == M_KEYED) || strm,
            (m_st[k] == M_EXPAND),
            (m_st[k] == M_KEYED) || strm,
            strm, last, (m_st[k] == M_ERROR), idx};
  endfunction

  task automatic go_expand(input int k);
    m_st[k] = M_EXPAND;
    m_tc[k] = 0;
  endtask

  task automatic model_step(input int k);
    if (rst) begin
      m_st[k] = M_IDLE;
      m_tc[k] = 0;
    end else begin
      case (m_st[k])
        M_IDLE:  if (key_load) go_expand(k);
        M_EXPAND: begin
          if (key_load) m_tc[k] = 0;
          else if (kexp_ready) m_st[k] = M_KEYED;
          else begin
            m_tc[k]++;
            if (TO_EN && m_tc[k] >= TO) m_st[k] = M_ERROR;
          end
        end
        M_KEYED: begin
          if (key_load) go_expand(k);
          else if (round_start) begin
            m_len[k] = m_nr[k] + 1;
            m_pos[k] = 0;
            for (int i = 0; i <= m_nr[k]; i++)
              m_seq[k][i] = round_dir ? (m_nr[k] - i) : i;
            m_st[k] = M_STREAM;
          end
        end
        M_STREAM: begin
          if (key_load) go_expand(k);
          else if (round_ack) begin
            m_pos[k]++;
            if (m_pos[k] == m_len[k]) m_st[k] = M_KEYED;
          end
        end
        M_ERROR: if (key_load) go_expand(k);
        default: m_st[k] = M_IDLE;
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_step(k);
    #1;
    cyc_n++;
    for (int k = 0; k < 2; k++)
      check($sformatf("nr%0d_cyc%0d", m_nr[k], cyc_n), obs_vec(k), exp_vec(k));
  endtask

  task automatic idle_inputs();
    key_load = 0; kexp_ready = 0; round_start = 0; round_dir = 0; round_ack = 0;
  endtask

  task automatic load_and_expand(input int wait_cycles);
    key_load = 1; cyc(); key_load = 0;
    repeat (wait_cycles) cyc();
    kexp_ready = 1; cyc(); kexp_ready = 0;
  endtask

  initial begin
    m_nr[0] = 10; m_nr[1] = 14;
    for (int k = 0; k < 2; k++) begin
      m_st[k] = M_IDLE; m_tc[k] = 0; m_len[k] = 0; m_pos[k] = 0;
    end
    rst = 1; idle_inputs();
    cyc(); cyc();
    check("reset_nr10", obs_vec(0), 10'd0);
    check("reset_nr14", obs_vec(1), 10'd0);

    // Key load at cycle 1, ready at cycle 12.
    rst = 0; cyc();
    key_load = 1; cyc(); key_load = 0;
    check("kexp_enable_c2", {9'd0, a_en}, 10'd1);
    repeat (10) cyc();
    kexp_ready = 1; cyc(); kexp_ready = 0;
    check("key_valid_c13", {9'd0, a_kv}, 10'd1);

    // Ascending sequence, ack every cycle.
    round_start = 1; round_dir = 0; cyc(); round_start = 0;
    check("asc_first_idx", {6'd0, a_idx}, 10'd0);
    round_ack = 1;
    repeat (10) cyc();
    check("asc_last_nr10", {5'd0, a_rl, a_idx}, {5'd0, 1'b1, 4'd10});
    repeat (5) cyc();
    round_ack = 0; cyc();
    check("asc_back_keyed", {8'd0, a_kv, a_rv}, 10'b10);

    // Descending sequence, ack every other cycle.
    round_start = 1; round_dir = 1; cyc(); round_start = 0;
    check("desc_first_idx14", {6'd0, b_idx}, 10'd14);
    for (int i = 0; i < 30; i++) begin
      round_ack = i[0];
      round_start = (i == 3);  // ignored while streaming
      cyc();
    end
    round_ack = 0; round_start = 0; cyc();

    // Abort at index 5 with key_load and ack together.
    round_start = 1; round_dir = 0; cyc(); round_start = 0;
    round_ack = 1; repeat (5) cyc(); round_ack = 0; cyc();
    check("abort_pre_idx5", {6'd0, b_idx}, 10'd5);
    key_load = 1; round_ack = 1; cyc(); key_load = 0; round_ack = 0;
    check("abort_expand", {6'd0, b_en, b_kb, b_kv, b_rv}, 10'b1100);
    cyc();
    kexp_ready = 1; cyc(); kexp_ready = 0;

    // Expansion timeout.
    key_load = 1; cyc(); key_load = 0;
    repeat (TO + 6) cyc();
    check("timeout_err", {9'd0, a_err}, {9'd0, TO_EN});
    key_load = 1; cyc(); key_load = 0;
    check("err_cleared", {8'd0, a_err, a_kb}, 10'b01);
    kexp_ready = 1; cyc(); kexp_ready = 0;

    // Reset in the middle of a sequence.
    round_start = 1; round_dir = 1; cyc(); round_start = 0;
    round_ack = 1; repeat (3) cyc(); round_ack = 0;
    rst = 1; round_start = 1; cyc(); rst = 0;
    check("midstream_rst", obs_vec(1), 10'd0);
    repeat (3) cyc();
    check("start_ignored_idle", obs_vec(1), 10'd0);
    round_start = 0;
    load_and_expand(2);

    // Randomised traffic.
    for (int i = 0; i < 600; i++) begin
      rst         = ($urandom_range(0, 99) == 0);
      key_load    = ($urandom_range(0, 19) == 0);
      kexp_ready  = ($urandom_range(0, 3) == 0);
      round_start = ($urandom_range(0, 3) == 0);
      round_dir   = $urandom_range(0, 1) == 1;
      round_ack   = $urandom_range(0, 1) == 1;
      cyc();
    end
    rst = 0; idle_inputs(); cyc();

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
`default_nettype wire
